multi_dev_bridge: RTL

MULTI_DEV_BRIDGE -- requirements
Module: multi_dev_bridge

---
 rtl/multi_dev_bridge_pkg.sv | 16 +
 rtl/multi_dev_bridge_decode.sv | 36 +++
 rtl/multi_dev_bridge.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/multi_dev_bridge_pkg.sv
// Shared definitions for the processor-to-DM/device bridge: FSM encoding and
// the fixed address map constants.
package multi_dev_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEV_WAIT = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

  localparam logic [31:0] DM_BASE      = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT     = 32'h0000_2FFF;
  localparam logic [31:0] INT_ACK_ADDR = 32'h0000_7F20;
  localparam logic [31:0] DEV_SPAN     = 32'd12;

endpackage

// File: rtl/multi_dev_bridge_decode.sv
// Address decoder for multi_dev_bridge: classifies pr_addr as data memory,
// one device slot (lowest index wins on overlap), or a miss.
module bridge_addr_decode
  import multi_dev_bridge_pkg::*;
#(
  parameter int unsigned         N_DEV    = 2,
  parameter logic [N_DEV*32-1:0] DEV_BASE = {32'h7F10, 32'h7F00}
) (
  input  logic [31:0]      pr_addr,
  output logic             dm_hit,
  output logic [N_DEV-1:0] dev_hit,
  output logic             miss
);

  logic [31:0] dm_off;
  logic [31:0] dev_off;
  logic        found;

  // Offset-based range checks wrap below the base, so one unsigned compare suffices.
  always_comb begin
    dm_off  = pr_addr - DM_BASE;
    dm_hit  = (dm_off <= (DM_LIMIT - DM_BASE));
    dev_hit = '0;
    dev_off = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      dev_off = pr_addr - DEV_BASE[i*32 +: 32];
      if (!dm_hit && !found && (dev_off < DEV_SPAN)) begin
        dev_hit[i] = 1'b1;
        found      = 1'b1;
      end
    end
    miss = !dm_hit && !found;
  end

endmodule

// File: rtl/multi_dev_bridge.sv
// Processor bus bridge to data memory and N_DEV memory-mapped devices.
// Optional device-acknowledge timeout: define BRIDGE_TIMEOUT_EN.
module multi_dev_bridge
  import multi_dev_bridge_pkg::*;
#(
  parameter int unsigned         N_DEV    = 2,
  parameter logic [N_DEV*32-1:0] DEV_BASE = {32'h7F10, 32'h7F00},
  parameter int unsigned         TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pr_req,
  input  logic [31:0]         pr_addr,
  input  logic [31:0]         pr_wd,
  input  logic                pr_we,
  input  logic [3:0]          pr_byteen,
  output logic                pr_ready,
  output logic [31:0]         pr_rd,
  output logic                pr_rd_valid,
  output logic                pr_err,
  output logic [31:0]         m_data_addr,
  output logic [31:0]         m_data_wdata,
  output logic [3:0]          m_data_byteen,
  input  logic [31:0]         m_data_rdata,
  output logic [31:0]         dev_addr,
  output logic [31:0]         dev_wd,
  output logic [N_DEV-1:0]    dev_we,
  output logic [N_DEV-1:0]    dev_sel,
  input  logic [N_DEV*32-1:0] dev_rd,
  input  logic [N_DEV-1:0]    dev_ack,
  input  logic                interrupt_respond
);

  state_e           state, state_nxt;
  logic             dm_hit, miss;
  logic [N_DEV-1:0] dev_hit;
  logic             dm_accept, dev_accept, miss_accept;
  logic             ack_hit, dev_done, dev_timeout;
  logic             dev_rd_req;
  logic [31:0]      dev_rd_sel;

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;
`endif

  bridge_addr_decode #(
    .N_DEV    (N_DEV),
    .DEV_BASE (DEV_BASE)
  ) u_decode (
    .pr_addr (pr_addr),
    .dm_hit  (dm_hit),
    .dev_hit (dev_hit),
    .miss    (miss)
  );

  always_comb begin
    dev_rd_sel = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (dev_sel[i]) dev_rd_sel = dev_rd[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pr_ready      = 1'b0;
    m_data_addr   = pr_addr;
    m_data_wdata  = pr_wd;
    m_data_byteen = '0;
    dm_accept     = 1'b0;
    dev_accept    = 1'b0;
    miss_accept   = 1'b0;
    dev_done      = 1'b0;
    dev_timeout   = 1'b0;
    ack_hit       = |(dev_ack & dev_sel);
    case (state)
      ST_IDLE: begin
        if (pr_req) begin
          if (dm_hit) begin
            // The interrupt strobe owns the DM port; the request is retried next cycle.
            if (!interrupt_respond) begin
              pr_ready      = 1'b1;
              dm_accept     = 1'b1;
              m_data_byteen = pr_byteen;
            end
          end else if (miss) begin
            pr_ready    = 1'b1;
            miss_accept = 1'b1;
          end else begin
            dev_accept = 1'b1;
            state_nxt  = ST_DEV_WAIT;
          end
        end
      end
      ST_DEV_WAIT: begin
        if (ack_hit) begin
          dev_done  = 1'b1;
          state_nxt = ST_RESP;
        end
`ifdef BRIDGE_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          dev_done    = 1'b1;
          dev_timeout = 1'b1;
          state_nxt   = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        pr_ready  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (interrupt_respond) begin
      m_data_addr   = INT_ACK_ADDR;
      m_data_byteen = '1;
    end
    // Combinational outputs are forced quiet while reset is held.
    if (!reset) begin
      pr_ready      = 1'b0;
      m_data_addr   = '0;
      m_data_wdata  = '0;
      m_data_byteen = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pr_rd       <= '0;
      pr_rd_valid <= 1'b0;
      pr_err      <= 1'b0;
      dev_sel     <= '0;
      dev_we      <= '0;
      dev_addr    <= '0;
      dev_wd      <= '0;
      dev_rd_req  <= 1'b0;
    end else begin
      pr_rd_valid <= 1'b0;
      pr_err      <= 1'b0;
      if (dm_accept && !pr_we) begin
        pr_rd       <= m_data_rdata;
        pr_rd_valid <= 1'b1;
      end
      if (miss_accept) begin
        pr_err <= 1'b1;
        if (!pr_we) begin
          pr_rd       <= '0;
          pr_rd_valid <= 1'b1;
        end
      end
      if (dev_accept) begin
        dev_addr   <= pr_addr;
        dev_wd     <= pr_wd;
        dev_sel    <= dev_hit;
        dev_we     <= pr_we ? dev_hit : '0;
        dev_rd_req <= !pr_we;
      end
      if (dev_done) begin
        dev_sel     <= '0;
        dev_we      <= '0;
        pr_rd_valid <= dev_rd_req;
        if (dev_timeout) begin
          pr_rd  <= '0;
          pr_err <= 1'b1;
        end else if (dev_rd_req) begin
          pr_rd <= dev_rd_sel;
        end
      end
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 tmo_cnt <= '0;
    else if (state == ST_DEV_WAIT && !dev_done) tmo_cnt <= tmo_cnt + 8'd1;
    else                                        tmo_cnt <= '0;
  end
`endif

endmodule
